// File: rtl/hvsync_decoder.sv
// Recovers pixel/line position from an external active-low hsync/vsync pair and tracks timing lock.
// Define HVSYNC_DECODER_SYNC_EN to put a two-flop synchronizer in front of the edge detectors.
module hvsync_decoder #(
    parameter int H_DISPLAY    = 640,
    parameter int H_TOTAL      = 800,
    parameter int H_SYNC_START = 656,
    parameter int V_DISPLAY    = 480,
    parameter int V_TOTAL      = 525,
    parameter int V_SYNC_START = 490,
    parameter int LOCK_LINES   = 4
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       hsync,
    input  logic       vsync,
    output logic [9:0] hpos,
    output logic [9:0] vpos,
    output logic       display_on,
    output logic       locked,
    output logic [7:0] err_count
);

    // state  | meaning
    // HUNT   | waiting for any hsync fall to start qualifying lines
    // TRACK  | counting consecutive lines whose hsync fall lands where expected
    // LOCKED | timing confirmed; a bad line or hsync timeout drops back to HUNT
    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SYNC_POS = 10'(H_SYNC_START);
    localparam logic [9:0] V_SYNC_POS = 10'(V_SYNC_START);
    localparam logic [9:0] H_DISP     = 10'(H_DISPLAY);
    localparam logic [9:0] V_DISP     = 10'(V_DISPLAY);
    localparam int         GW         = $clog2(LOCK_LINES + 1);
    localparam logic [GW-1:0] GOOD_TGT = GW'(LOCK_LINES);
    localparam int         TW         = $clog2(2 * H_TOTAL);
    localparam logic [TW-1:0] TO_LOAD = TW'(2 * H_TOTAL - 1);

    logic          hs_in, vs_in;
    logic          hs_q, hs_prev, vs_q, vs_prev;
    logic          hs_fall, vs_fall;
    logic [9:0]    hpos_free;
    logic          line_good;
    logic          timeout;
    state_t        state, state_nxt;
    logic [GW-1:0] good_cnt, good_nxt, good_inc;
    logic [TW-1:0] to_cnt;
    logic          err_inc;

`ifdef HVSYNC_DECODER_SYNC_EN
    logic [1:0] hs_meta, vs_meta;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            hs_meta <= 2'b11;
            vs_meta <= 2'b11;
        end else begin
            hs_meta <= {hs_meta[0], hsync};
            vs_meta <= {vs_meta[0], vsync};
        end
    end

    assign hs_in = hs_meta[1];
    assign vs_in = vs_meta[1];
`else
    assign hs_in = hsync;
    assign vs_in = vsync;
`endif

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            hs_q    <= 1'b1;
            hs_prev <= 1'b1;
            vs_q    <= 1'b1;
            vs_prev <= 1'b1;
        end else begin
            hs_q    <= hs_in;
            hs_prev <= hs_q;
            vs_q    <= vs_in;
            vs_prev <= vs_q;
        end
    end

    assign hs_fall = hs_prev & ~hs_q;
    assign vs_fall = vs_prev & ~vs_q;

    // Where hpos would go without a sync load; a line is good if the fall agrees with it.
    assign hpos_free = (hpos == H_LAST) ? 10'd0 : hpos + 10'd1;
    assign line_good = (hpos_free == H_SYNC_POS);

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            hpos <= 10'd0;
            vpos <= 10'd0;
        end else begin
            hpos <= hs_fall ? H_SYNC_POS : hpos_free;
            if (vs_fall)
                vpos <= V_SYNC_POS;
            else if (!hs_fall && hpos == H_LAST)
                vpos <= (vpos == V_LAST) ? 10'd0 : vpos + 10'd1;
        end
    end

    // Down-counter reloaded by every hsync fall; reaching zero means 2*H_TOTAL quiet cycles.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset)
            to_cnt <= TO_LOAD;
        else if (hs_fall)
            to_cnt <= TO_LOAD;
        else if (to_cnt != '0)
            to_cnt <= to_cnt - 1'b1;
    end

    assign timeout  = !hs_fall && (to_cnt == '0);
    assign good_inc = good_cnt + 1'b1;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state     <= HUNT;
            good_cnt  <= '0;
            err_count <= 8'd0;
        end else begin
            state    <= state_nxt;
            good_cnt <= good_nxt;
            if (err_inc && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        good_nxt  = good_cnt;
        err_inc   = 1'b0;
        if (timeout) begin
            state_nxt = HUNT;
            good_nxt  = '0;
            err_inc   = (state == LOCKED);
        end else if (hs_fall) begin
            case (state)
                HUNT: begin
                    state_nxt = TRACK;
                    good_nxt  = '0;
                end
                TRACK: begin
                    if (!line_good) begin
                        good_nxt = '0;
                    end else if (good_inc == GOOD_TGT) begin
                        state_nxt = LOCKED;
                        good_nxt  = '0;
                    end else begin
                        good_nxt = good_inc;
                    end
                end
                LOCKED: begin
                    if (!line_good) begin
                        state_nxt = HUNT;
                        err_inc   = 1'b1;
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end
    end

    assign locked     = (state == LOCKED);
    assign display_on = locked && (hpos < H_DISP) && (vpos < V_DISP);

endmodule

// File: tb/tb_hvsync_decoder.sv
// Directed bench for hvsync_decoder: a default 800x525 instance plus a short-line
// instance (LOCK_LINES=1) used to reach error-counter saturation quickly.
module tb_hvsync_decoder;

    logic       CLK = 1'b0;
    logic       reset, hsync, vsync;
    logic [9:0] hpos, vpos;
    logic       display_on, locked;
    logic [7:0] err_count;

    logic       reset_s, hsync_s, vsync_s;
    logic [9:0] hpos_s, vpos_s;
    logic       display_on_s, locked_s;
    logic [7:0] err_count_s;

    int n_cmp = 0;
    int n_err = 0;

    hvsync_decoder dut (
        .CLK(CLK), .reset(reset), .hsync(hsync), .vsync(vsync),
        .hpos(hpos), .vpos(vpos), .display_on(display_on),
        .locked(locked), .err_count(err_count)
    );

    hvsync_decoder #(
        .H_DISPLAY(10), .H_TOTAL(20), .H_SYNC_START(12),
        .V_DISPLAY(4), .V_TOTAL(8), .V_SYNC_START(5), .LOCK_LINES(1)
    ) dut_s (
        .CLK(CLK), .reset(reset_s), .hsync(hsync_s), .vsync(vsync_s),
        .hpos(hpos_s), .vpos(vpos_s), .display_on(display_on_s),
        .locked(locked_s), .err_count(err_count_s)
    );

    always #5 CLK = ~CLK;

    initial begin
        #3000000;
        $display("FAIL watchdog: time limit reached, got no summary, required completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int len;
        int exp_locked;
        int exp_err;
        int exp_disp;
    } row_t;

    row_t rows[12];

    int s_hpos2, s_vpos2, s_locked2, s_err2, s_hpos146, s_vpos146, s_hpos150, s_disp150;
    int s_hpos_s2;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One source line: hsync fall at i=0, 96-cycle pulse; snapshots taken at fixed offsets.
    task automatic run_line(input int len, input logic vs_val);
        for (int i = 0; i < len; i++) begin
            @(negedge CLK);
            if (i == 2) begin
                s_hpos2 = hpos; s_vpos2 = vpos; s_locked2 = locked; s_err2 = err_count;
            end
            if (i == 146) begin
                s_hpos146 = hpos; s_vpos146 = vpos;
            end
            if (i == 150) begin
                s_hpos150 = hpos; s_disp150 = display_on;
            end
            hsync = (i < 96) ? 1'b0 : 1'b1;
            vsync = vs_val;
        end
    endtask

    task automatic apply_row(input int r);
        run_line(rows[r].len, 1'b1);
        chk($sformatf("row%0d hpos after fall", r), s_hpos2, 656);
        chk($sformatf("row%0d locked", r), s_locked2, rows[r].exp_locked);
        chk($sformatf("row%0d err_count", r), s_err2, rows[r].exp_err);
        chk($sformatf("row%0d hpos after wrap", r), s_hpos150, 4);
        chk($sformatf("row%0d display_on", r), s_disp150, rows[r].exp_disp);
    endtask

    task automatic sline(input int len);
        for (int i = 0; i < len; i++) begin
            @(negedge CLK);
            if (i == 2) s_hpos_s2 = hpos_s;
            hsync_s = (i < 4) ? 1'b0 : 1'b1;
        end
    endtask

    initial begin
        // len, locked after this line's fall, err_count, display_on at hpos=4
        rows[0]  = '{800, 0, 0, 0};
        rows[1]  = '{800, 0, 0, 0};
        rows[2]  = '{800, 0, 0, 0};
        rows[3]  = '{800, 0, 0, 0};
        rows[4]  = '{800, 1, 0, 1};
        rows[5]  = '{797, 1, 0, 1};
        rows[6]  = '{803, 0, 1, 0};
        rows[7]  = '{800, 0, 1, 0};
        rows[8]  = '{800, 0, 1, 0};
        rows[9]  = '{800, 0, 1, 0};
        rows[10] = '{800, 0, 1, 0};
        rows[11] = '{800, 1, 1, 1};

        reset = 1'b0; hsync = 1'b1; vsync = 1'b1;
        reset_s = 1'b0; hsync_s = 1'b1; vsync_s = 1'b1;
        repeat (3) @(negedge CLK);
        chk("reset hpos", hpos, 0);
        chk("reset vpos", vpos, 0);
        chk("reset locked", locked, 0);
        chk("reset display_on", display_on, 0);
        chk("reset err_count", err_count, 0);
        chk("small reset vpos", vpos_s, 0);
        chk("small reset display_on", display_on_s, 0);
        reset = 1'b1;
        reset_s = 1'b1;

        // Lock acquisition, one early fall, relock.
        for (int r = 0; r < 12; r++) apply_row(r);

        // hsync held high after a good fall: timeout after 1600 quiet cycles.
        for (int i = 0; i < 1700; i++) begin
            @(negedge CLK);
            if (i == 2) chk("timeout locked after good fall", locked, 1);
            if (i == 1601) chk("timeout locked before limit", locked, 1);
            if (i == 1602) begin
                chk("timeout locked after limit", locked, 0);
                chk("timeout err_count", err_count, 2);
            end
            hsync = (i < 96) ? 1'b0 : 1'b1;
        end

        // Coincident hsync/vsync falls, then vpos counting through its wrap.
        run_line(800, 1'b0);
        chk("coincident hpos", s_hpos2, 656);
        chk("coincident vpos", s_vpos2, 490);
        chk("hpos wrap to 0", s_hpos146, 0);
        chk("vpos inc on hpos wrap", s_vpos146, 491);
        for (int m = 1; m <= 34; m++) begin
            run_line(800, 1'b1);
            if (m == 3) chk("vtest locked before 4th good", s_locked2, 0);
            if (m == 4) chk("vtest locked at 4th good", s_locked2, 1);
            if (m == 33) begin
                chk("vpos last line", s_vpos146, 524);
                chk("display_on off below V_DISPLAY", s_disp150, 0);
            end
            if (m == 34) begin
                chk("vpos wrap to 0", s_vpos146, 0);
                chk("display_on at line 0", s_disp150, 1);
            end
        end

        // Reset asserted mid-line at hpos=300.
        for (int i = 0; i < 800; i++) begin
            @(negedge CLK);
            if (i == 446) begin
                chk("pre-reset hpos", hpos, 300);
                chk("pre-reset err_count", err_count, 2);
                chk("pre-reset locked", locked, 1);
                reset = 1'b0;
                #1;
                chk("async reset hpos", hpos, 0);
                chk("async reset vpos", vpos, 0);
                chk("async reset locked", locked, 0);
                chk("async reset display_on", display_on, 0);
                chk("async reset err_count", err_count, 0);
            end
            if (i == 450) reset = 1'b1;
            if (i == 799) chk("post-reset locked before any fall", locked, 0);
            hsync = (i < 96) ? 1'b0 : 1'b1;
        end
        for (int r = 0; r < 5; r++) apply_row(r);

        // Short-line instance: repeated lock/loss cycles until err_count saturates.
        sline(20);
        sline(17);
        chk("small hpos after fall", s_hpos_s2, 12);
        for (int j = 1; j <= 260; j++) begin
            if (j == 1 || j == 255) chk($sformatf("small locked before loss %0d", j), locked_s, 1);
            sline(20);
            if (j == 1) chk("small locked after loss", locked_s, 0);
            if (j == 1 || j == 2 || j == 128 || j == 255 || j == 256 || j == 260)
                chk($sformatf("small err_count after loss %0d", j), err_count_s, (j > 255) ? 255 : j);
            sline(20);
            sline(17);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
